// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_pkg
// Description : Shared definitions for the program-counter sequencer:
//               state encodings and the default fetch address width.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_pkg;

  // Default fetch address width
  localparam int unsigned PC_ADDR_W = 9;

  // Sequencer state encoding
  typedef logic [1:0] pc_state_t;

  localparam pc_state_t PC_BOOT = 2'd0;
  localparam pc_state_t PC_RUN  = 2'd1;
  localparam pc_state_t PC_HALT = 2'd2;

endpackage
`default_nettype wire

// File: rtl/pc_redirect_buf.sv
`default_nettype none
// ============================================================================
// Module      : pc_redirect_buf
// Description : One-entry pending-redirect register. A load overwrites any
//               entry already held (latest target wins); clear empties it.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_redirect_buf
  import pc_pkg::*;
#(
  parameter int unsigned ADDR_W = PC_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              clear,
  output logic              valid,
  output logic [ADDR_W-1:0] addr
);

  logic              r_valid;
  logic [ADDR_W-1:0] r_addr;

  // Entry register; load has priority over clear so a redirect arriving in
  // the same cycle as a clear is never lost
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
    end else if (load) begin
      r_valid <= 1'b1;
      r_addr  <= load_addr;
    end else if (clear) begin
      r_valid <= 1'b0;
    end
  end

  assign valid = r_valid;
  assign addr  = r_addr;

endmodule
`default_nettype wire

// File: rtl/pc_seq_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_seq_unit
// Description : Fetch-side program-counter sequencer with stall hold,
//               branch/jump redirect (one-entry pending buffer during
//               stalls) and a programmable end address that either halts
//               the sequencer or wraps it back to RESET_ADDR.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_seq_unit
  import pc_pkg::*;
#(
  parameter int unsigned ADDR_W     = PC_ADDR_W,
  parameter int unsigned RESET_ADDR = 0,
  parameter int unsigned INCR       = 1,
  parameter int unsigned END_ADDR   = 14,
  parameter int unsigned WRAP_EN    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_en,
  input  logic              redir_valid,
  input  logic [ADDR_W-1:0] redir_addr,
  input  logic              resume,
  output logic [ADDR_W-1:0] pc_addr,
  output logic              pc_valid,
  output logic              halted
);

  localparam logic [ADDR_W-1:0] c_reset_addr = RESET_ADDR[ADDR_W-1:0];
  localparam logic [ADDR_W:0]   c_end_ext    = {1'b0, END_ADDR[ADDR_W-1:0]};
  localparam logic [ADDR_W:0]   c_incr_ext   = INCR[ADDR_W:0];

  // Elaboration-time sanity check of the address parameters
  if ((RESET_ADDR >= (2 ** ADDR_W)) || (END_ADDR >= (2 ** ADDR_W)) ||
      (END_ADDR < RESET_ADDR)) begin : g_param_check
    $error("pc_seq_unit: RESET_ADDR/END_ADDR must fit ADDR_W and END_ADDR >= RESET_ADDR");
  end

  pc_state_t         r_state;
  pc_state_t         w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic              r_valid;
  logic              w_valid_nxt;
  logic              r_halted;
  logic              w_halted_nxt;

  logic              w_buf_load;
  logic              w_buf_clear;
  logic              w_buf_valid;
  logic [ADDR_W-1:0] w_buf_addr;

  logic [ADDR_W:0]   w_seq_ext;
  logic [ADDR_W:0]   w_redir_ext;
  logic              w_redir_oor;
  logic [ADDR_W:0]   w_target_ext;

  pc_redirect_buf #(
    .ADDR_W (ADDR_W)
  ) u_redirect_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (w_buf_load),
    .load_addr (redir_addr),
    .clear     (w_buf_clear),
    .valid     (w_buf_valid),
    .addr      (w_buf_addr)
  );

  // Targets are evaluated one bit wider so a carry out of ADDR_W shows up
  // as a value above END_ADDR (whose extra bit is always zero)
  assign w_seq_ext   = {1'b0, r_pc} + c_incr_ext;
  assign w_redir_ext = {1'b0, redir_addr};
  assign w_redir_oor = (w_redir_ext > c_end_ext);

  // State, PC and status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= PC_BOOT;
      r_pc     <= c_reset_addr;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_valid  <= w_valid_nxt;
      r_halted <= w_halted_nxt;
    end
  end

  // Next-state, next-PC selection and pending-buffer control
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_valid_nxt  = r_valid;
    w_halted_nxt = r_halted;
    w_buf_load   = 1'b0;
    w_buf_clear  = 1'b1;
    w_target_ext = w_seq_ext;

    case (r_state)
      PC_BOOT: begin
        w_state_nxt  = PC_RUN;
        w_pc_nxt     = c_reset_addr;
        w_valid_nxt  = 1'b1;
        w_halted_nxt = 1'b0;
      end

      PC_RUN: begin
        if (stall_en) begin
          // Hold the PC; a redirect seen now is parked until the stall drops
          w_buf_clear = 1'b0;
          w_buf_load  = redir_valid;
        end else begin
          if (redir_valid) begin
            w_target_ext = w_redir_ext;
          end else if (w_buf_valid) begin
            w_target_ext = {1'b0, w_buf_addr};
          end

          if (w_target_ext > c_end_ext) begin
            if (WRAP_EN != 0) begin
              w_pc_nxt = c_reset_addr;
            end else begin
              // PC keeps the last legal address while halted
              w_state_nxt  = PC_HALT;
              w_valid_nxt  = 1'b0;
              w_halted_nxt = 1'b1;
            end
          end else begin
            w_pc_nxt = w_target_ext[ADDR_W-1:0];
          end
        end
      end

      PC_HALT: begin
        if (redir_valid && !w_redir_oor) begin
          w_state_nxt  = PC_RUN;
          w_pc_nxt     = redir_addr;
          w_valid_nxt  = 1'b1;
          w_halted_nxt = 1'b0;
        end else if (resume) begin
          w_state_nxt  = PC_RUN;
          w_pc_nxt     = c_reset_addr;
          w_valid_nxt  = 1'b1;
          w_halted_nxt = 1'b0;
        end
      end

      default: begin
        w_state_nxt  = PC_BOOT;
        w_pc_nxt     = c_reset_addr;
        w_valid_nxt  = 1'b0;
        w_halted_nxt = 1'b0;
      end
    endcase
  end

  assign pc_addr  = r_pc;
  assign pc_valid = r_valid;
  assign halted   = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_pc_seq_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_seq_unit
// Description : Directed self-checking bench for pc_seq_unit. Instance A uses
//               default parameters (halt at END_ADDR), instance B wraps.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_seq_unit;

  logic       clk;
  logic       rst;
  logic       stall_en;
  logic       redir_valid;
  logic [8:0] redir_addr;
  logic       resume;
  logic [8:0] pc_addr;
  logic       pc_valid;
  logic       halted;

  logic       rst_b;
  logic       stall_b;
  logic       redir_valid_b;
  logic [8:0] redir_addr_b;
  logic       resume_b;
  logic [8:0] pc_addr_b;
  logic       pc_valid_b;
  logic       halted_b;

  int n_checks;
  int n_errors;

  pc_seq_unit u_dut_a (
    .clk         (clk),
    .rst         (rst),
    .stall_en    (stall_en),
    .redir_valid (redir_valid),
    .redir_addr  (redir_addr),
    .resume      (resume),
    .pc_addr     (pc_addr),
    .pc_valid    (pc_valid),
    .halted      (halted)
  );

  pc_seq_unit #(
    .WRAP_EN (1)
  ) u_dut_b (
    .clk         (clk),
    .rst         (rst_b),
    .stall_en    (stall_b),
    .redir_valid (redir_valid_b),
    .redir_addr  (redir_addr_b),
    .resume      (resume_b),
    .pc_addr     (pc_addr_b),
    .pc_valid    (pc_valid_b),
    .halted      (halted_b)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input int pc, input int v, input int h);
    check({tag, ".pc"},     32'(pc_addr),  32'(pc));
    check({tag, ".valid"},  32'(pc_valid), 32'(v));
    check({tag, ".halted"}, 32'(halted),   32'(h));
  endtask

  task automatic chk_b(input string tag, input int pc);
    check({tag, ".b_pc"},     32'(pc_addr_b),  32'(pc));
    check({tag, ".b_valid"},  32'(pc_valid_b), 32'd1);
    check({tag, ".b_halted"}, 32'(halted_b),   32'd0);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst           = 1'b1;
    stall_en      = 1'b0;
    redir_valid   = 1'b0;
    redir_addr    = '0;
    resume        = 1'b0;
    rst_b         = 1'b1;
    stall_b       = 1'b0;
    redir_valid_b = 1'b0;
    redir_addr_b  = '0;
    resume_b      = 1'b0;

    // Reset state
    tick();
    tick();
    chk_a("reset", 0, 0, 0);
    check("reset.b_valid", 32'(pc_valid_b), 32'd0);
    rst   = 1'b0;
    rst_b = 1'b0;

    // Free run 0..14, then halt (A) / wrap (B)
    tick();
    chk_a("boot", 0, 1, 0);
    chk_b("boot", 0);
    for (int i = 1; i <= 14; i++) begin
      tick();
      chk_a("run", i, 1, 0);
      chk_b("run", i);
    end
    tick();
    chk_a("end_halt", 14, 0, 1);
    chk_b("wrap0", 0);

    // HALT: redirect beats resume
    resume      = 1'b1;
    redir_valid = 1'b1;
    redir_addr  = 9'd2;
    tick();
    chk_a("halt_redir", 2, 1, 0);
    chk_b("wrap1", 1);
    resume      = 1'b0;
    redir_valid = 1'b0;

    for (int i = 3; i <= 5; i++) begin
      tick();
      chk_a("seq", i, 1, 0);
    end

    // Stall three cycles at 5
    stall_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_a("stall_hold", 5, 1, 0);
    end
    stall_en = 1'b0;
    tick();
    chk_a("stall_release", 6, 1, 0);

    // Redirect to 3, then redirect at 3 to 10
    redir_valid = 1'b1;
    redir_addr  = 9'd3;
    tick();
    chk_a("redir3", 3, 1, 0);
    redir_addr = 9'd10;
    tick();
    chk_a("redir10", 10, 1, 0);
    redir_valid = 1'b0;

    // Redirects during a stall: latest wins
    stall_en    = 1'b1;
    redir_valid = 1'b1;
    redir_addr  = 9'd7;
    tick();
    chk_a("pend_stall1", 10, 1, 0);
    redir_addr = 9'd9;
    tick();
    chk_a("pend_stall2", 10, 1, 0);
    redir_valid = 1'b0;
    tick();
    chk_a("pend_stall3", 10, 1, 0);
    stall_en = 1'b0;
    tick();
    chk_a("pend_take", 9, 1, 0);
    tick();
    chk_a("pend_next", 10, 1, 0);

    // Out-of-range redirect in RUN halts, PC holds
    redir_valid = 1'b1;
    redir_addr  = 9'd20;
    tick();
    chk_a("oor_halt", 10, 0, 1);

    // In HALT: out-of-range redirect ignored, stall ignored
    stall_en   = 1'b1;
    redir_addr = 9'd300;
    tick();
    chk_a("halt_ignore", 10, 0, 1);

    // Resume taken when the redirect is out of range
    resume = 1'b1;
    tick();
    chk_a("resume", 0, 1, 0);
    resume      = 1'b0;
    redir_valid = 1'b0;

    // Reset with a pending redirect discards it
    redir_valid = 1'b1;
    redir_addr  = 9'd12;
    tick();
    chk_a("pend_before_rst", 0, 1, 0);
    redir_valid = 1'b0;
    rst         = 1'b1;
    tick();
    chk_a("rst_boot", 0, 0, 0);
    rst      = 1'b0;
    stall_en = 1'b0;
    tick();
    chk_a("rst_run", 0, 1, 0);
    tick();
    chk_a("rst_no_pend", 1, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
